// File: rtl/tick_timer.sv
// Down-counting interval timer clocked in divider ticks; pulses 'expired' for one
// cycle when a started interval runs out. Cancel, restart and hold can interrupt it.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  input  logic         cancel,
  output logic         busy,
  output logic         expired,
  output logic [W-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   remaining_q, remaining_d;
  logic           expired_q, expired_d;

  logic           load_is_zero;
  logic           last_tick;

  assign load_is_zero = (load_val == '0);
  assign last_tick    = (remaining_q == W'(1));

  // Priority within a cycle: cancel > start > hold > tick; expired defaults low so it is a pulse.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        remaining_d = '0;
        if (!cancel && start) begin
          if (load_is_zero) begin
            expired_d = 1'b1;
          end else begin
            state_d     = RUN;
            remaining_d = load_val;
          end
        end
      end

      RUN: begin
        if (cancel) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (start) begin
          if (load_is_zero) begin
            state_d     = IDLE;
            remaining_d = '0;
            expired_d   = 1'b1;
          end else begin
            remaining_d = load_val;
          end
        end else if (!hold && tick) begin
          if (last_tick || (remaining_q == '0)) begin
            state_d     = IDLE;
            remaining_d = '0;
            expired_d   = 1'b1;
          end else begin
            remaining_d = remaining_q - W'(1);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign expired   = expired_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_tick_timer.sv
// Randomised and directed bench for tick_timer, checked against an integer-level
// behavioural model of the timer's rules.
module tb_tick_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [7:0] load_val;
  logic       hold;
  logic       cancel;
  logic       busy;
  logic       expired;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;

  // Behavioural model: just "is a timer running, how many units are left, did it just finish".
  bit m_busy;
  int m_rem;
  bit m_exp;

  tick_timer #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .load_val  (load_val),
    .hold      (hold),
    .cancel    (cancel),
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input bit t, input bit s, input int lv, input bit h,
                              input bit c, input bit r);
    if (r) begin
      m_busy = 0; m_rem = 0; m_exp = 0;
    end else begin
      m_exp = 0;
      if (c) begin
        m_busy = 0; m_rem = 0;
      end else if (s) begin
        if (lv == 0) begin
          m_busy = 0; m_rem = 0; m_exp = 1;
        end else begin
          m_busy = 1; m_rem = lv;
        end
      end else if (m_busy && !h && t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0; m_exp = 1;
        end
      end
    end
  endtask

  // Drive one clock cycle of inputs, advance the model at the edge, settle outputs.
  task automatic drive(input bit t, input bit s, input logic [7:0] lv, input bit h,
                       input bit c, input bit r);
    tick = t; start = s; load_val = lv; hold = h; cancel = c; reset = r;
    @(posedge clk);
    model_update(t, s, int'(lv), h, c, r);
    #1;
    tick = 0; start = 0; load_val = 8'd0; cancel = 0; reset = 0;
  endtask

  task automatic test_reset;
    drive(0, 0, 8'd0, 0, 0, 1);
    drive(0, 0, 8'd0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (remaining !== 8'd0) begin errors++; $display("[TB] FAIL reset_remaining: got %0d want 0", remaining); end
    checks++;
    if (expired !== 1'b0) begin errors++; $display("[TB] FAIL reset_expired: got %b want 0", expired); end
  endtask

  task automatic test_basic;
    int pulses = 0;
    int seen_rem[$];
    drive(0, 1, 8'd3, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || remaining !== 8'd3) begin
      errors++; $display("[TB] FAIL basic_start: busy=%b rem=%0d want busy=1 rem=3", busy, remaining);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive((cyc % 4) == 3, 0, 8'd0, 0, 0, 0);
      checks++;
      if (busy !== m_busy || remaining !== 8'(m_rem) || expired !== m_exp) begin
        errors++;
        $display("[TB] FAIL basic_step: got b=%b r=%0d e=%b want b=%b r=%0d e=%b",
                 busy, remaining, expired, m_busy, m_rem, m_exp);
      end
      if (expired === 1'b1) begin
        pulses++;
        checks++;
        if (busy !== 1'b0 || remaining !== 8'd0 || cyc != 11) begin
          errors++;
          $display("[TB] FAIL basic_expiry: cyc=%0d busy=%b rem=%0d want cyc=11 busy=0 rem=0",
                   cyc, busy, remaining);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL basic_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_zero_load;
    drive(0, 1, 8'd0, 0, 0, 0);
    checks++;
    if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 8'd0) begin
      errors++; $display("[TB] FAIL zero_load: e=%b b=%b r=%0d want e=1 b=0 r=0", expired, busy, remaining);
    end
    drive(1, 0, 8'd0, 0, 0, 0);
    checks++;
    if (expired !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_load_clear: e=%b b=%b want e=0 b=0", expired, busy);
    end
  endtask

  task automatic test_hold;
    int ticks_sent = 0;
    int expired_at = -1;
    bit t;
    bit h;
    drive(0, 1, 8'd5, 0, 0, 0);
    for (int cyc = 0; cyc < 60 && expired_at < 0; cyc++) begin
      t = (cyc % 4) == 3;
      h = (ticks_sent == 2 || ticks_sent == 3) ? 1'b1 : 1'b0;
      hold = h;
      drive(t, 0, 8'd0, h, 0, 0);
      if (t) ticks_sent++;
      if (h) begin
        checks++;
        if (remaining !== 8'd3) begin
          errors++; $display("[TB] FAIL hold_frozen: got %0d want 3", remaining);
        end
      end
      if (expired === 1'b1) expired_at = ticks_sent;
    end
    hold = 0;
    checks++;
    if (expired_at != 7) begin
      errors++; $display("[TB] FAIL hold_expiry_ticks: got %0d want 7", expired_at);
    end
  endtask

  task automatic test_restart;
    drive(0, 1, 8'd4, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);
    checks++;
    if (remaining !== 8'd2) begin errors++; $display("[TB] FAIL restart_pre: got %0d want 2", remaining); end
    drive(1, 1, 8'd6, 0, 0, 0);
    checks++;
    if (remaining !== 8'd6 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_value: got r=%0d b=%b want r=6 b=1", remaining, busy);
    end
    drive(1, 1, 8'd9, 0, 1, 0);
    checks++;
    if (busy !== 1'b0 || remaining !== 8'd0 || expired !== 1'b0) begin
      errors++; $display("[TB] FAIL cancel_priority: b=%b r=%0d e=%b want 0 0 0", busy, remaining, expired);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'd0, 0, 0, 0);
      checks++;
      if (expired !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL cancel_quiet: e=%b b=%b want 0 0", expired, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int ticks_sent = 0;
    bit done = 0;
    drive(0, 1, 8'd255, 0, 0, 0);
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      drive(cyc[0], 0, 8'd0, 0, 0, 0);
      if (cyc[0]) ticks_sent++;
      checks++;
      if (busy !== m_busy || remaining !== 8'(m_rem) || expired !== m_exp) begin
        errors++;
        $display("[TB] FAIL boundary_step: got b=%b r=%0d e=%b want b=%b r=%0d e=%b",
                 busy, remaining, expired, m_busy, m_rem, m_exp);
      end
      if (expired === 1'b1) begin
        pulses++;
        done = 1;
      end
    end
    checks++;
    if (pulses != 1 || ticks_sent != 255) begin
      errors++; $display("[TB] FAIL boundary_count: pulses=%0d ticks=%0d want 1 255", pulses, ticks_sent);
    end
    drive(0, 1, 8'd10, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || remaining !== 8'd10 || expired !== 1'b0) begin
      errors++; $display("[TB] FAIL back_to_back: b=%b r=%0d e=%b want 1 10 0", busy, remaining, expired);
    end
    drive(0, 0, 8'd0, 0, 1, 0);
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 8'd6, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);
    checks++;
    if (remaining !== 8'd4) begin errors++; $display("[TB] FAIL reset_mid_pre: got %0d want 4", remaining); end
    drive(1, 0, 8'd0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || remaining !== 8'd0 || expired !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid: b=%b r=%0d e=%b want 0 0 0", busy, remaining, expired);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'd0, 0, 0, 0);
      checks++;
      if (expired !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_quiet: e=%b want 0", expired); end
    end
  endtask

  task automatic test_random;
    bit t, s, h, c, r;
    logic [7:0] lv;
    for (int i = 0; i < 3000; i++) begin
      t  = ($urandom_range(0, 99) < 35);
      s  = ($urandom_range(0, 99) < 6);
      c  = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 199) < 1);
      if ($urandom_range(0, 99) < 5) hold = ~hold;
      h  = hold;
      lv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      drive(t, s, lv, h, c, r);
      checks++;
      if (busy !== m_busy || remaining !== 8'(m_rem) || expired !== m_exp) begin
        errors++;
        $display("[TB] FAIL random_step %0d: got b=%b r=%0d e=%b want b=%b r=%0d e=%b",
                 i, busy, remaining, expired, m_busy, m_rem, m_exp);
      end
    end
    hold = 0;
  endtask

  initial begin
    tick = 0; start = 0; load_val = 8'd0; hold = 0; cancel = 0; reset = 1;
    m_busy = 0; m_rem = 0; m_exp = 0;
    test_reset;
    test_basic;
    test_zero_load;
    test_hold;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
